// File: rtl/nn_pkg.sv
// Shared NN pipeline types and constants.
// Defaults are shared with the softmax stage.
package nn_pkg;

  localparam int NN_Q_FRAC_BITS = 16;
  localparam int NN_DATA_W      = NN_Q_FRAC_BITS;
  localparam int NN_N_CLASSES   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/nn_class_argmax_if.sv
// Probability-beat input and result-record output bundle
// for the argmax classifier stage.
interface nn_class_argmax_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [IDX_W-1:0]  in_label;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_max;
  logic              out_correct;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_last, in_label, out_ready,
    input  in_ready, out_valid, out_idx, out_max,
    input  out_correct, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, in_label, out_ready,
    output in_ready, out_valid, out_idx, out_max,
    output out_correct, out_err
  );
endinterface

// File: rtl/nn_acc_counter.sv
// Saturating, clearable total/correct counter pair.
// A clear overrides a same-cycle increment.
module nn_acc_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             hit,
  output logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] correct
);
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] correct_q, correct_d;

  always_comb begin
    total_d   = total_q;
    correct_d = correct_q;
    if (clr) begin
      total_d   = '0;
      correct_d = '0;
    end else if (inc) begin
      if (total_q != '1)
        total_d = total_q + CNT_W'(1);
      if (hit && correct_q != '1)
        correct_d = correct_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q   <= '0;
      correct_q <= '0;
    end else begin
      total_q   <= total_d;
      correct_q <= correct_d;
    end
  end

  assign total   = total_q;
  assign correct = correct_q;
endmodule

// File: rtl/nn_class_argmax.sv
// Streaming argmax classifier: one result record per vector.
// Define NN_ARGMAX_ACC_EN to add the epoch accuracy tally.
module nn_class_argmax
  import nn_pkg::*;
#(
  parameter int N_CLASSES = NN_N_CLASSES,
  parameter int DATA_W    = NN_DATA_W,
  parameter int IDX_W     = $clog2(N_CLASSES)
`ifdef NN_ARGMAX_ACC_EN
  ,
  parameter int CNT_W     = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  nn_class_argmax_if.slave bus
`ifdef NN_ARGMAX_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [CNT_W-1:0] acc_total,
  output logic [CNT_W-1:0] acc_correct
`endif
);
  // Counter must reach N_CLASSES+1 so over-long vectors stay distinguishable.
  localparam int CW = $clog2(N_CLASSES + 2);
  localparam logic [CW-1:0] N_C = CW'(N_CLASSES);
  localparam logic [CW-1:0] SAT = CW'(N_CLASSES + 1);

  argmax_state_t     state_q, state_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [IDX_W-1:0]  label_q, label_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              corr_q, corr_d;
  logic              in_ready;
  logic              out_valid;
  logic              last;

  always_comb begin
    state_d    = state_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    label_d    = label_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    corr_d     = corr_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    last       = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          best_val_d = bus.in_data;
          best_idx_d = '0;
          label_d    = bus.in_label;
          cnt_d      = CW'(1);
          last       = bus.in_last;
          state_d    = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (cnt_q < N_C && bus.in_data > best_val_q) begin
            best_val_d = bus.in_data;
            best_idx_d = IDX_W'(cnt_q);
          end
          if (cnt_q != SAT)
            cnt_d = cnt_q + CW'(1);
          last = bus.in_last;
          if (bus.in_last)
            state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (last) begin
      err_d  = (cnt_d != N_C);
      corr_d = (best_idx_d == label_d) && (cnt_d == N_C);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      best_val_q <= '0;
      best_idx_q <= '0;
      label_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      corr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      label_q    <= label_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      corr_q     <= corr_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_idx     = best_idx_q;
  assign bus.out_max     = best_val_q;
  assign bus.out_correct = corr_q;
  assign bus.out_err     = err_q;

`ifdef NN_ARGMAX_ACC_EN
  nn_acc_counter #(
    .CNT_W (CNT_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .inc     (out_valid & bus.out_ready),
    .hit     (corr_q),
    .total   (acc_total),
    .correct (acc_correct)
  );
`endif
endmodule

// File: tb/tb_nn_class_argmax.sv
// Self-checking bench for nn_class_argmax (N_CLASSES=4).
// Covers NN_ARGMAX_ACC_EN when the macro is defined.
module tb_nn_class_argmax;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [DW-1:0] vd [8];
  logic clr_on_hs = 1'b0;

  nn_class_argmax_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

`ifdef NN_ARGMAX_ACC_EN
  logic        acc_clr = 1'b0;
  logic [31:0] acc_total;
  logic [31:0] acc_correct;
`endif

  nn_class_argmax #(
    .N_CLASSES (N),
    .DATA_W    (DW),
    .IDX_W     (IW)
`ifdef NN_ARGMAX_ACC_EN
    ,
    .CNT_W     (32)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef NN_ARGMAX_ACC_EN
    ,
    .acc_clr     (acc_clr),
    .acc_total   (acc_total),
    .acc_correct (acc_correct)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            len;
    logic [DW-1:0] d [8];
    logic [IW-1:0] lab;
    logic [IW-1:0] e_idx;
    logic [DW-1:0] e_max;
    logic          e_corr;
    logic          e_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: argmax over the first min(len,N) beats, lowest index on ties.
  function automatic void model(input int len, input logic [IW-1:0] lab,
                                output logic [IW-1:0] idx,
                                output logic [DW-1:0] mx,
                                output logic corr, output logic err);
    int n;
    n   = (len < N) ? len : N;
    mx  = vd[0];
    idx = '0;
    for (int i = 1; i < n; i++)
      if (vd[i] > mx) begin
        mx  = vd[i];
        idx = IW'(i);
      end
    err  = (len != N);
    corr = (idx == lab) && !err;
  endfunction

  task automatic drive_beat(input logic [DW-1:0] d, input logic last,
                            input logic [IW-1:0] lab, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 16'hFFFF;
      bus.in_last  = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_label = lab;
    t = 0;
    while (bus.in_ready !== 1'b1) begin
      if (t >= 50) begin
        chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
      @(negedge clk);
      t++;
    end
    @(posedge clk);
  endtask

  task automatic send_vec(input int len, input logic [IW-1:0] lab,
                          input logic gaps);
    for (int i = 0; i < len; i++)
      drive_beat(vd[i], i == len - 1, (i == 0) ? lab : lab + IW'(1),
                 gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic collect(input logic [IW-1:0] e_idx, input logic [DW-1:0] e_max,
                         input logic e_corr, input logic e_err, input int hold);
    logic [IW-1:0] idx0;
    logic [DW-1:0] max0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    chk("out_idx", 32'(bus.out_idx), 32'(e_idx));
    chk("out_max", 32'(bus.out_max), 32'(e_max));
    chk("out_correct", 32'(bus.out_correct), 32'(e_corr));
    chk("out_err", 32'(bus.out_err), 32'(e_err));
    idx0 = bus.out_idx;
    max0 = bus.out_max;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_idx", 32'(bus.out_idx), 32'(idx0));
      chk("hold_max", 32'(bus.out_max), 32'(max0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
`ifdef NN_ARGMAX_ACC_EN
    acc_clr = clr_on_hs;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
`ifdef NN_ARGMAX_ACC_EN
    acc_clr = 1'b0;
`endif
    chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] m_idx;
    logic [DW-1:0] m_max;
    logic          m_corr, m_err;
    int            len;
    logic [IW-1:0] lab;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_label  = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{4, '{16'h1000, 16'h8000, 16'h3000, 16'h4000, 0, 0, 0, 0},
               2'd1, 2'd1, 16'h8000, 1'b1, 1'b0};
    tbl[1] = '{4, '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 0, 0, 0, 0},
               2'd2, 2'd0, 16'h4000, 1'b0, 1'b0};
    tbl[2] = '{3, '{16'h1000, 16'h2000, 16'h9000, 0, 0, 0, 0, 0},
               2'd2, 2'd2, 16'h9000, 1'b0, 1'b1};
    tbl[3] = '{6, '{16'h1000, 16'h2000, 16'h3000, 16'h4000,
                    16'hFFFF, 16'hFFFF, 0, 0},
               2'd3, 2'd3, 16'h4000, 1'b0, 1'b1};
    tbl[4] = '{4, '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0, 0},
               2'd0, 2'd0, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{4, '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0},
               2'd0, 2'd0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{1, '{16'h7777, 0, 0, 0, 0, 0, 0, 0},
               2'd0, 2'd0, 16'h7777, 1'b0, 1'b1};
    tbl[7] = '{4, '{16'h0001, 16'h0002, 16'h0003, 16'hFFFE, 0, 0, 0, 0},
               2'd3, 2'd3, 16'hFFFE, 1'b1, 1'b0};
    tbl[8] = '{8, '{16'h0000, 16'h0000, 16'h0000, 16'h0001,
                    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
               2'd3, 2'd3, 16'h0001, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_max", 32'(bus.out_max), 32'd0);
    chk("rst_out_correct", 32'(bus.out_correct), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
`ifdef NN_ARGMAX_ACC_EN
    chk("rst_acc_total", acc_total, 32'd0);
    chk("rst_acc_correct", acc_correct, 32'd0);
`endif
    rst = 1'b0;

    foreach (tbl[k]) begin
      vd = tbl[k].d;
      send_vec(tbl[k].len, tbl[k].lab, 1'b0);
      collect(tbl[k].e_idx, tbl[k].e_max, tbl[k].e_corr, tbl[k].e_err, 0);
    end

    // Back-pressure: record held five cycles, no input accepted meanwhile.
    vd = tbl[0].d;
    send_vec(4, 2'd1, 1'b0);
    collect(2'd1, 16'h8000, 1'b1, 1'b0, 5);

    // Reset pulsed during the third beat.
    vd = '{16'h1000, 16'hF000, 16'h2000, 16'h3000, 0, 0, 0, 0};
    drive_beat(vd[0], 1'b0, 2'd1, 0);
    drive_beat(vd[1], 1'b0, 2'd0, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = vd[2];
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid_out_max", 32'(bus.out_max), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    vd = '{16'h0100, 16'h0200, 16'h0300, 16'h9000, 0, 0, 0, 0};
    send_vec(4, 2'd3, 1'b0);
    collect(2'd3, 16'h9000, 1'b1, 1'b0, 0);

    for (int r = 0; r < 60; r++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : N;
      lab = IW'($urandom_range(0, N - 1));
      for (int i = 0; i < 8; i++)
        case ($urandom_range(0, 3))
          0:       vd[i] = 16'hFFFF;
          1:       vd[i] = 16'h8000;
          default: vd[i] = DW'($urandom);
        endcase
      model(len, lab, m_idx, m_max, m_corr, m_err);
      send_vec(len, lab, 1'b1);
      collect(m_idx, m_max, m_corr, m_err, int'($urandom_range(0, 2)));
    end

`ifdef NN_ARGMAX_ACC_EN
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("acc_clr_total", acc_total, 32'd0);
    chk("acc_clr_correct", acc_correct, 32'd0);
    for (int k = 0; k < 3; k++) begin
      vd = tbl[0].d;
      send_vec(4, 2'd1, 1'b0);
      collect(2'd1, 16'h8000, 1'b1, 1'b0, 0);
    end
    vd = tbl[2].d;
    send_vec(3, 2'd2, 1'b0);
    collect(2'd2, 16'h9000, 1'b0, 1'b1, 0);
    chk("acc_total_4", acc_total, 32'd4);
    chk("acc_correct_3", acc_correct, 32'd3);
    clr_on_hs = 1'b1;
    vd = tbl[0].d;
    send_vec(4, 2'd1, 1'b0);
    collect(2'd1, 16'h8000, 1'b1, 1'b0, 0);
    clr_on_hs = 1'b0;
    chk("acc_clr_hs_total", acc_total, 32'd0);
    chk("acc_clr_hs_correct", acc_correct, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
